mem_arbiter: RTL and testbench

Two-master round-robin arbiter that shares the single-port BRAM controller between the CPU instruction-fetch port (m0) and the load/store port (m1). Both sides use the same valid/ready/addr/wdata/wstrb/rdata memory bus. The block sits between the core and the BRAM controller and serialises accesses. An optional watchdog completes a transaction with an error if the slave never answers.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_watchdog.sv | 27 ++
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the two-master BRAM arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
  localparam logic        OWNER_M0  = 1'b0;
  localparam logic        OWNER_M1  = 1'b1;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not own last.
  function automatic logic next_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return !last;
    return v1 ? OWNER_M1 : OWNER_M0;
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// rtl/mem_arbiter_watchdog.sv - cycle watchdog, expires after TIMEOUT_CYCLES enabled cycles
module mem_arbiter_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  assign expire = enable && (count == CW'(TIMEOUT_CYCLES - 1));

  // Expiry restarts the count so the next enabled phase gets a full window.
  always_ff @(posedge clk) begin
    if (reset || clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one BRAM controller between m0 and m1
// Optional slave watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        owner,
  output logic        timeout_err
);

  if (TIMEOUT_CYCLES < 4) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 4");
  end

  arb_state_t state;
  logic       owner_valid;
  logic       complete;
  logic       wd_expire;
  logic       wd_fire;

  assign owner_valid = (owner == OWNER_M1) ? m1_valid : m0_valid;
  assign s_addr      = (owner == OWNER_M1) ? m1_addr  : m0_addr;
  assign s_wdata     = (owner == OWNER_M1) ? m1_wdata : m0_wdata;
  assign s_wstrb     = (owner == OWNER_M1) ? m1_wstrb : m0_wstrb;

  assign complete = !reset && (state == BUSY) && s_ready;

`ifdef MEM_ARBITER_TIMEOUT_EN
  mem_arbiter_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable (state != IDLE),
    .expire (wd_expire)
  );

  // Completion by the slave always wins over the watchdog in the same cycle.
  assign wd_fire = !reset && (state == BUSY) && owner_valid && !s_ready && wd_expire;
`else
  assign wd_expire = 1'b0;
  assign wd_fire   = 1'b0;
`endif

  assign s_valid     = !reset && (state == BUSY) && owner_valid;
  assign timeout_err = wd_fire;

  assign m0_ready = (complete || wd_fire) && (owner == OWNER_M0);
  assign m1_ready = (complete || wd_fire) && (owner == OWNER_M1);
  assign m0_rdata = (wd_fire && owner == OWNER_M0) ? ERR_RDATA : s_rdata;
  assign m1_rdata = (wd_fire && owner == OWNER_M1) ? ERR_RDATA : s_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWNER_M1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            owner <= next_grant(m0_valid, m1_valid, owner);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (wd_fire) begin
            state <= RECOVER;
          end else if (s_ready || !owner_valid) begin
            state <= IDLE;
          end
        end
        RECOVER: begin
          if (s_ready || wd_expire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural BRAM slave
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        owner, timeout_err;

  logic        s_ready_r;
  logic        stray;
  logic        preload;
  logic        stall;
  int          wait_cycles;
  int          scnt;
  logic [31:0] mem [0:63];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_rsp_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] addr;
    logic [3:0]  wstrb;
  } exp_gnt_t;

  exp_rsp_t q0[$];
  exp_rsp_t q1[$];
  exp_gnt_t qg[$];

  logic chk_gap;
  int   cyc;
  int   last_rdy;
  logic have_rdy;
  logic sv_prev;

  always #5 clk = ~clk;

  assign s_ready = s_ready_r | stray;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_valid    (m0_valid),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_wstrb    (m0_wstrb),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_wstrb    (m1_wstrb),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_rdata     (s_rdata),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'hF000_1537 : (32'hC0DE_0000 | 32'(i));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // BRAM model: s_ready pulses wait_cycles cycles after s_valid first appears.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end
    if (reset) begin
      s_ready_r <= 1'b0;
      scnt      <= 0;
      s_rdata   <= '0;
    end else if (s_ready_r) begin
      s_ready_r <= 1'b0;
    end else if (s_valid && !stall) begin
      if (scnt == wait_cycles - 1) begin
        s_ready_r          <= 1'b1;
        scnt               <= 0;
        mem[s_addr[7:2]]   <= merge(mem[s_addr[7:2]], s_wdata, s_wstrb);
        s_rdata            <= merge(mem[s_addr[7:2]], s_wdata, s_wstrb);
      end else begin
        scnt <= scnt + 1;
      end
    end else if (!s_valid) begin
      scnt <= 0;
    end
  end

  always @(negedge clk) begin
    exp_rsp_t e;
    exp_gnt_t g;
    cyc     <= cyc + 1;
    sv_prev <= s_valid;
    if (!chk_gap) have_rdy <= 1'b0;
    if (!reset) begin
      if (s_valid && !sv_prev) begin
        check("gnt_expected", 32'(qg.size() != 0), 32'd1);
        if (qg.size() != 0) begin
          g = qg.pop_front();
          check("gnt_owner", 32'(owner), 32'(g.owner));
          check("gnt_addr", s_addr, g.addr);
          check("gnt_wstrb", 32'(s_wstrb), 32'(g.wstrb));
          if (chk_gap && have_rdy) check("gnt_gap", 32'(cyc - last_rdy), 32'd2);
        end
      end
      if (m0_ready) begin
        check("m0_excl", 32'(m1_ready), 32'd0);
        check("m0_owner", 32'(owner), 32'd0);
        check("m0_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("m0_rdata", m0_rdata, e.rdata);
          check("m0_err", 32'(timeout_err), 32'(e.err));
        end
      end
      if (m1_ready) begin
        check("m1_owner", 32'(owner), 32'd1);
        check("m1_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("m1_rdata", m1_rdata, e.rdata);
          check("m1_err", 32'(timeout_err), 32'(e.err));
        end
      end
      if (timeout_err) check("err_with_ready", 32'(m0_ready | m1_ready), 32'd1);
      if (m0_ready || m1_ready) begin
        last_rdy <= cyc;
        if (chk_gap) have_rdy <= 1'b1;
      end
    end
  end

  task automatic exp_grant(input logic o, input logic [31:0] a, input logic [3:0] s);
    exp_gnt_t g;
    g.owner = o;
    g.addr  = a;
    g.wstrb = s;
    qg.push_back(g);
  endtask

  // Called just after a rising edge; returns just after the edge that follows the ready cycle.
  task automatic do_req(input logic m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_rd, input logic exp_err, output int lat);
    exp_rsp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    if (m) begin
      q1.push_back(e);
      m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end else begin
      q0.push_back(e);
      m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end
    lat = 0;
    forever begin
      @(negedge clk);
      if (m ? m1_ready : m0_ready) break;
      lat++;
      if (lat > 300) begin
        check("req_wait", 32'(lat), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (m) m1_valid = 1'b0;
    else   m0_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    int lat0, lat1;
    reset = 1'b1; preload = 1'b1; stall = 1'b0; stray = 1'b0; wait_cycles = 3;
    chk_gap = 1'b0; cyc = 0; last_rdy = 0; have_rdy = 1'b0; sv_prev = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    m0_valid = 1'b1;
    @(negedge clk);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);
    check("rst_m1_ready", 32'(m1_ready), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_owner", 32'(owner), 32'd1);
    @(posedge clk);
    #1;
    m0_valid = 1'b0;
    reset = 1'b0;

    // single m0 read
    exp_grant(1'b0, 32'h0, 4'h0);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 32'hF000_1537, 1'b0, lat);
    check("t1_lat", 32'(lat), 32'd4);

    // m1 write then m0 read-back
    exp_grant(1'b1, 32'h80, 4'hF);
    do_req(1'b1, 32'h80, 32'h0000_0037, 4'hF, 32'h0000_0037, 1'b0, lat);
    check("t2_wr_lat", 32'(lat), 32'd4);
    exp_grant(1'b0, 32'h80, 4'h0);
    do_req(1'b0, 32'h80, 32'h0, 4'h0, 32'h0000_0037, 1'b0, lat);
    check("t2_rd_lat", 32'(lat), 32'd4);

    // contention: strict alternation starting with m0 after reset
    do_reset();
    @(negedge clk);
    check("t3_rst_owner", 32'(owner), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_grant(1'b0, 32'h10 + 32'(4 * i), 4'h0);
      exp_grant(1'b1, 32'h20 + 32'(4 * i), 4'h0);
    end
    chk_gap = 1'b1;
    fork
      for (int i = 0; i < 3; i++) do_req(1'b0, 32'h10 + 32'(4 * i), 32'h0, 4'h0, init_word(4 + i), 1'b0, lat0);
      for (int j = 0; j < 3; j++) do_req(1'b1, 32'h20 + 32'(4 * j), 32'h0, 4'h0, init_word(8 + j), 1'b0, lat1);
    join
    chk_gap = 1'b0;
    check("t3_grants_left", 32'(qg.size()), 32'd0);

    // reset in cycle 2 of an m1 write
    exp_grant(1'b1, 32'h40, 4'hF);
    m1_valid = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    m1_valid = 1'b0;
    @(negedge clk);
    check("t4_in_rst_s_valid", 32'(s_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t4_s_valid", 32'(s_valid), 32'd0);
    check("t4_m1_ready", 32'(m1_ready), 32'd0);
    check("t4_owner", 32'(owner), 32'd1);
    @(posedge clk);
    #1;
    exp_grant(1'b0, 32'h40, 4'h0);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, init_word(16), 1'b0, lat);
    check("t4_idle_lat", 32'(lat), 32'd4);

    // stray s_ready while idle
    stray = 1'b1;
    @(negedge clk);
    check("t5_m0_ready", 32'(m0_ready), 32'd0);
    check("t5_m1_ready", 32'(m1_ready), 32'd0);
    @(posedge clk);
    #1;
    stray = 1'b0;

    // m0 aborts after two cycles: no ready, arbiter free again
    exp_grant(1'b0, 32'h8, 4'h0);
    m0_valid = 1'b1; m0_addr = 32'h8; m0_wstrb = 4'h0;
    repeat (2) begin @(posedge clk); #1; end
    m0_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t6_no_ready", 32'(m0_ready | m1_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    exp_grant(1'b1, 32'hC, 4'h0);
    do_req(1'b1, 32'hC, 32'h0, 4'h0, init_word(3), 1'b0, lat);
    check("t6_after_abort_lat", 32'(lat), 32'd4);

    // partial strobe is forwarded unchanged
    exp_grant(1'b1, 32'h44, 4'b0011);
    do_req(1'b1, 32'h44, 32'hAAAA_BBBB, 4'b0011, 32'hC0DE_BBBB, 1'b0, lat);

    // slow slave completes normally
    wait_cycles = 6;
    exp_grant(1'b0, 32'h0, 4'h0);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 32'hF000_1537, 1'b0, lat);
    check("t8_slow_lat", 32'(lat), 32'd7);
    wait_cycles = 3;

`ifdef MEM_ARBITER_TIMEOUT_EN
    stall = 1'b1;
    exp_grant(1'b0, 32'h4, 4'h0);
    do_req(1'b0, 32'h4, 32'h0, 4'h0, ERR_RDATA, 1'b1, lat);
    check("t9_timeout_lat", 32'(lat), 32'(TO));
    stall = 1'b0;
    exp_grant(1'b1, 32'h8, 4'h0);
    do_req(1'b1, 32'h8, 32'h0, 4'h0, init_word(2), 1'b0, lat);
    check("t9_recover_lat", 32'(lat), 32'(TO + 4));
`else
    stall = 1'b1;
    exp_grant(1'b0, 32'h4, 4'h0);
    fork
      do_req(1'b0, 32'h4, 32'h0, 4'h0, init_word(1), 1'b0, lat);
      begin
        repeat (40) @(posedge clk);
        #1;
        stall = 1'b0;
      end
    join
    check("t9_wait_lat", 32'(lat), 32'd43);
`endif

    repeat (4) @(posedge clk);
    check("end_rsp_q0", 32'(q0.size()), 32'd0);
    check("end_rsp_q1", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
